// File: rtl/risc_v_processor.sv
// Single-cycle RV64I-subset core: fetch, decode, execute and retire in one clock.
// Instruction/data memories, register file and ALU are all internal.
module risc_v_processor (
    input  logic clk,
    input  logic reset
);
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    logic [7:0]  imem   [0:255];
    logic [7:0]  dmem_q [0:255];
    logic [63:0] regs_q [0:31];
    logic [63:0] regs_d [0:31];
    logic [63:0] pc_q, pc_d;

    initial begin
        for (int i = 0; i < 256; i++) begin
            imem[i]   = 8'h00;
            dmem_q[i] = 8'h00;
        end
    end

    logic [7:0]  pc_b;
    logic [31:0] instr;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [63:0] imm_i, imm_b;
    logic [63:0] rs1_val, rs2_val;
    logic signed [63:0] rs1_s, rs2_s;
    logic [7:0]  ld_addr, st_addr;
    logic [63:0] ld_data;
    logic        wb_en, st_en, br_taken;
    logic [63:0] wb_data;

    assign pc_b  = pc_q[7:0];
    assign instr = {imem[pc_b + 8'd3], imem[pc_b + 8'd2], imem[pc_b + 8'd1], imem[pc_b]};

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign imm_i = {{52{instr[31]}}, instr[31:20]};
    assign imm_b = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

    assign rs1_val = (rs1 == 5'd0) ? 64'd0 : regs_q[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 64'd0 : regs_q[rs2];
    assign rs1_s   = rs1_val;
    assign rs2_s   = rs2_val;

    // Data memory is 256 bytes, so only the low 8 bits of rs1+imm ever matter.
    assign ld_addr = rs1_val[7:0] + instr[27:20];
    assign st_addr = rs1_val[7:0] + {instr[27:25], instr[11:7]};

    always_comb begin
        ld_data = '0;
        for (int k = 0; k < 8; k++) begin
            ld_data[8*k +: 8] = dmem_q[ld_addr + 8'(k)];
        end
    end

    always_comb begin
        wb_en    = 1'b0;
        wb_data  = '0;
        st_en    = 1'b0;
        br_taken = 1'b0;
        case (opcode)
            OP_R: begin
                case (funct3)
                    3'b000: begin
                        if (funct7 == 7'b0000000) begin
                            wb_en   = 1'b1;
                            wb_data = rs1_val + rs2_val;
                        end else if (funct7 == 7'b0100000) begin
                            wb_en   = 1'b1;
                            wb_data = rs1_val - rs2_val;
                        end
                    end
                    3'b001: begin
                        wb_en   = 1'b1;
                        wb_data = rs1_val << rs2_val[5:0];
                    end
                    3'b101: begin
                        if (funct7 == 7'b0000000) begin
                            wb_en   = 1'b1;
                            wb_data = rs1_val >> rs2_val[5:0];
                        end
                    end
                    3'b111: begin
                        wb_en   = 1'b1;
                        wb_data = rs1_val & rs2_val;
                    end
                    3'b110: begin
                        wb_en   = 1'b1;
                        wb_data = rs1_val | rs2_val;
                    end
                    default: ;
                endcase
            end
            OP_I: begin
                wb_en = 1'b1;
                case (funct3)
                    3'b000:  wb_data = rs1_val + imm_i;
                    3'b111:  wb_data = rs1_val & imm_i;
                    3'b110:  wb_data = rs1_val | imm_i;
                    3'b001:  wb_data = rs1_val << imm_i[5:0];
                    3'b101:  wb_data = rs1_val >> imm_i[5:0];
                    default: wb_en   = 1'b0;
                endcase
            end
            OP_LD: begin
                if (funct3 == 3'b011) begin
                    wb_en   = 1'b1;
                    wb_data = ld_data;
                end
            end
            OP_ST: st_en = (funct3 == 3'b011);
            OP_BR: begin
                case (funct3)
                    3'b000:  br_taken = (rs1_val == rs2_val);
                    3'b001:  br_taken = (rs1_val != rs2_val);
                    3'b100:  br_taken = (rs1_s < rs2_s);
                    3'b101:  br_taken = (rs1_s >= rs2_s);
                    default: br_taken = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        pc_d   = br_taken ? (pc_q + imm_b) : (pc_q + 64'd4);
        regs_d = regs_q;
        if (wb_en && (rd != 5'd0)) begin
            regs_d[rd] = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            pc_q   <= pc_d;
            regs_q <= regs_d;
        end
    end

    // Memory contents survive reset; only the store itself is suppressed.
    always_ff @(posedge clk) begin
        if (!reset && st_en) begin
            for (int k = 0; k < 8; k++) begin
                dmem_q[st_addr + 8'(k)] <= rs2_val[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_risc_v_processor.sv
// Directed bench for risc_v_processor: table of small programs plus hand-written
// sequences for halt, fetch wrap, misaligned stores and reset behaviour.
module tb_risc_v_processor;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    typedef logic [7:0][31:0] prog_t;
    typedef struct {
        string       name;
        prog_t       prog;
        int          ncyc;
        int          rd;
        logic [63:0] exp_reg;
        logic [63:0] exp_pc;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    risc_v_processor dut (.clk(clk), .reset(reset));

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), OP_R};
    endfunction
    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
        return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction
    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
        logic [11:0] im;
        im = 12'(imm);
        return {im[11:5], 5'(rs2), 5'(rs1), 3'b011, im[4:0], OP_ST};
    endfunction
    function automatic logic [31:0] enc_b(int off, int rs2, int rs1, int f3);
        logic [12:0] im;
        im = 13'(off);
        return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], OP_BR};
    endfunction

    function automatic logic [31:0] a_addi(int rd, int rs1, int imm); return enc_i(imm, rs1, 0, rd, OP_I); endfunction
    function automatic logic [31:0] a_andi(int rd, int rs1, int imm); return enc_i(imm, rs1, 7, rd, OP_I); endfunction
    function automatic logic [31:0] a_ori (int rd, int rs1, int imm); return enc_i(imm, rs1, 6, rd, OP_I); endfunction
    function automatic logic [31:0] a_slli(int rd, int rs1, int sh);  return enc_i(sh, rs1, 1, rd, OP_I); endfunction
    function automatic logic [31:0] a_srli(int rd, int rs1, int sh);  return enc_i(sh, rs1, 5, rd, OP_I); endfunction
    function automatic logic [31:0] a_ld  (int rd, int rs1, int imm); return enc_i(imm, rs1, 3, rd, OP_LD); endfunction
    function automatic logic [31:0] a_sd  (int rs2, int rs1, int imm); return enc_s(imm, rs2, rs1); endfunction
    function automatic logic [31:0] a_add (int rd, int rs1, int rs2); return enc_r(7'h00, rs2, rs1, 0, rd); endfunction
    function automatic logic [31:0] a_sub (int rd, int rs1, int rs2); return enc_r(7'h20, rs2, rs1, 0, rd); endfunction
    function automatic logic [31:0] a_sll (int rd, int rs1, int rs2); return enc_r(7'h00, rs2, rs1, 1, rd); endfunction
    function automatic logic [31:0] a_srl (int rd, int rs1, int rs2); return enc_r(7'h00, rs2, rs1, 5, rd); endfunction
    function automatic logic [31:0] a_and (int rd, int rs1, int rs2); return enc_r(7'h00, rs2, rs1, 7, rd); endfunction
    function automatic logic [31:0] a_or  (int rd, int rs1, int rs2); return enc_r(7'h00, rs2, rs1, 6, rd); endfunction
    function automatic logic [31:0] a_beq (int rs1, int rs2, int off); return enc_b(off, rs2, rs1, 0); endfunction
    function automatic logic [31:0] a_bne (int rs1, int rs2, int off); return enc_b(off, rs2, rs1, 1); endfunction
    function automatic logic [31:0] a_blt (int rs1, int rs2, int off); return enc_b(off, rs2, rs1, 4); endfunction
    function automatic logic [31:0] a_bge (int rs1, int rs2, int off); return enc_b(off, rs2, rs1, 5); endfunction

    function automatic vec_t mk(string n, prog_t p, int c, int rd, logic [63:0] er, logic [63:0] ep);
        vec_t v;
        v.name = n; v.prog = p; v.ncyc = c; v.rd = rd; v.exp_reg = er; v.exp_pc = ep;
        return v;
    endfunction

    task automatic chk64(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
        end
    endtask

    task automatic load_prog(prog_t p);
        for (int i = 0; i < 256; i++) dut.imem[i] = 8'h00;
        for (int w = 0; w < 8; w++)
            for (int b = 0; b < 4; b++)
                dut.imem[4*w + b] = p[w][8*b +: 8];
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    function automatic int nonzero_regs();
        int nz = 0;
        for (int i = 1; i < 32; i++) if (dut.regs_q[i] !== 64'd0) nz++;
        return nz;
    endfunction

    prog_t alu, mem, x0p, beqp, bltp, bgep, loopp, sllp, srlp, logp, nopp, p;
    vec_t  vt[$];

    initial begin
        reset = 1'b1;
        alu = '0;
        alu[0] = a_addi(1, 0, 5);   alu[1] = a_addi(2, 0, -3);
        alu[2] = a_add(3, 1, 2);    alu[3] = a_sub(4, 1, 2);
        alu[4] = a_and(5, 1, 2);    alu[5] = a_or(6, 1, 2);
        alu[6] = a_slli(7, 1, 3);   alu[7] = a_srli(8, 2, 60);
        mem = '0;
        mem[0] = a_addi(1, 0, 'h123); mem[1] = a_sd(1, 0, 16); mem[2] = a_ld(2, 0, 16);
        x0p = '0;
        x0p[0] = a_addi(0, 0, 7); x0p[1] = a_addi(1, 0, 1); x0p[2] = a_add(2, 0, 1);
        beqp = '0;
        beqp[0] = a_addi(1, 0, 1); beqp[1] = a_beq(1, 1, 8);
        beqp[2] = a_addi(5, 0, 1); beqp[3] = a_addi(6, 0, 2);
        bltp = '0;
        bltp[0] = a_addi(1, 0, -1); bltp[1] = a_addi(2, 0, 1); bltp[2] = a_blt(1, 2, 8);
        bltp[3] = a_addi(3, 0, 7);  bltp[4] = a_addi(4, 0, 9);
        bgep = bltp;
        bgep[2] = a_bge(1, 2, 8);
        loopp = '0;
        loopp[0] = a_addi(4, 0, 10); loopp[1] = a_addi(3, 3, 1);
        loopp[2] = a_bne(3, 4, -4);  loopp[3] = a_beq(0, 0, 0);
        sllp = '0;
        sllp[0] = a_addi(1, 0, 1); sllp[1] = a_addi(2, 0, 65); sllp[2] = a_sll(3, 1, 2);
        srlp = '0;
        srlp[0] = a_addi(1, 0, -1); srlp[1] = a_addi(2, 0, 63); srlp[2] = a_srl(3, 1, 2);
        logp = '0;
        logp[0] = a_addi(1, 0, 'hF0); logp[1] = a_ori(2, 1, 'h0F); logp[2] = a_andi(3, 2, -16);
        nopp = '0;
        nopp[0] = a_addi(1, 0, 3); nopp[1] = enc_r(7'h01, 1, 1, 0, 2);

        vt.push_back(mk("alu_add",  alu, 8, 3, 64'd2, 64'd32));
        vt.push_back(mk("alu_sub",  alu, 8, 4, 64'd8, 64'd32));
        vt.push_back(mk("alu_and",  alu, 8, 5, 64'd5, 64'd32));
        vt.push_back(mk("alu_or",   alu, 8, 6, 64'hFFFF_FFFF_FFFF_FFFD, 64'd32));
        vt.push_back(mk("alu_slli", alu, 8, 7, 64'd40, 64'd32));
        vt.push_back(mk("alu_srli", alu, 8, 8, 64'hF, 64'd32));
        vt.push_back(mk("sd_ld",    mem, 3, 2, 64'h123, 64'd12));
        vt.push_back(mk("x0_use",   x0p, 3, 2, 64'd1, 64'd12));
        vt.push_back(mk("x0_store", x0p, 3, 0, 64'd0, 64'd12));
        vt.push_back(mk("beq_skip", beqp, 4, 5, 64'd0, 64'd20));
        vt.push_back(mk("beq_tgt",  beqp, 4, 6, 64'd2, 64'd20));
        vt.push_back(mk("blt_take", bltp, 4, 3, 64'd0, 64'd20));
        vt.push_back(mk("bge_not",  bgep, 4, 3, 64'd7, 64'd16));
        vt.push_back(mk("bne_loop", loopp, 30, 3, 64'd10, 64'd12));
        vt.push_back(mk("sll_6bit", sllp, 3, 3, 64'd2, 64'd12));
        vt.push_back(mk("srl_63",   srlp, 3, 3, 64'd1, 64'd12));
        vt.push_back(mk("ori",      logp, 3, 2, 64'hFF, 64'd12));
        vt.push_back(mk("andi_neg", logp, 3, 3, 64'hF0, 64'd12));
        vt.push_back(mk("bad_f7",   nopp, 2, 2, 64'd0, 64'd8));

        // Reset from power-up, then first instruction.
        #2;
        load_prog(alu);
        tick(1);
        reset = 1'b0;
        chk64("reset_pc", dut.pc_q, 64'd0);
        chk64("reset_regs_nonzero", 64'(nonzero_regs()), 64'd0);
        tick(1);
        chk64("first_pc", dut.pc_q, 64'd4);
        chk64("first_x1", dut.regs_q[1], 64'd5);

        foreach (vt[i]) begin
            load_prog(vt[i].prog);
            do_reset();
            tick(vt[i].ncyc);
            chk64({vt[i].name, "_reg"}, dut.regs_q[5'(vt[i].rd)], vt[i].exp_reg);
            chk64({vt[i].name, "_pc"}, dut.pc_q, vt[i].exp_pc);
        end

        chk64("dmem16_byte", 64'(dut.dmem_q[16]), 64'h23);
        chk64("dmem16_dword", {dut.dmem_q[23], dut.dmem_q[22], dut.dmem_q[21], dut.dmem_q[20],
                               dut.dmem_q[19], dut.dmem_q[18], dut.dmem_q[17], dut.dmem_q[16]}, 64'h123);

        // Halt loop holds PC for the rest of a 400-cycle run.
        p = '0;
        p[0] = a_addi(1, 0, 1); p[1] = a_beq(0, 0, 0);
        load_prog(p);
        do_reset();
        tick(2);
        begin
            int bad = 0;
            repeat (398) begin
                tick(1);
                if (dut.pc_q !== 64'd4) bad++;
            end
            chk64("halt_pc_moved_cycles", 64'(bad), 64'd0);
        end
        chk64("halt_x1", dut.regs_q[1], 64'd1);

        // Zero words are NOPs; fetch wraps modulo 256 while PC keeps counting.
        p = '0;
        p[0] = a_addi(1, 1, 1);
        load_prog(p);
        do_reset();
        tick(64);
        chk64("wrap_pc256", dut.pc_q, 64'd256);
        chk64("wrap_x1_once", dut.regs_q[1], 64'd1);
        tick(1);
        chk64("wrap_pc260", dut.pc_q, 64'd260);
        chk64("wrap_x1_twice", dut.regs_q[1], 64'd2);

        // Doubleword store straddling the end of data memory.
        p = '0;
        p[0] = a_addi(5, 0, 252); p[1] = a_addi(1, 0, -2);
        p[2] = a_sd(1, 5, 0);     p[3] = a_ld(6, 5, 0);
        load_prog(p);
        do_reset();
        tick(4);
        chk64("mis_ld", dut.regs_q[6], 64'hFFFF_FFFF_FFFF_FFFE);
        chk64("mis_b252", 64'(dut.dmem_q[252]), 64'hFE);
        chk64("mis_b3", 64'(dut.dmem_q[3]), 64'hFF);
        chk64("mis_b4", 64'(dut.dmem_q[4]), 64'h00);
        chk64("mis_b251", 64'(dut.dmem_q[251]), 64'h00);

        // A store in flight during reset must not commit.
        p = '0;
        p[0] = a_addi(1, 0, 'h55); p[1] = a_sd(1, 0, 40); p[2] = a_beq(0, 0, 0);
        load_prog(p);
        do_reset();
        tick(3);
        chk64("st40_setup", 64'(dut.dmem_q[40]), 64'h55);
        p = '0;
        p[0] = a_sd(0, 0, 40);
        load_prog(p);
        reset = 1'b1;
        tick(2);
        chk64("st40_held_in_reset", 64'(dut.dmem_q[40]), 64'h55);
        reset = 1'b0;
        tick(1);
        chk64("st40_after_release", 64'(dut.dmem_q[40]), 64'h00);
        chk64("st40_pc", dut.pc_q, 64'd4);

        // Mid-run reset after 20 cycles of the counting loop.
        load_prog(loopp);
        do_reset();
        tick(20);
        chk64("mid_x3_before", dut.regs_q[3], 64'd10);
        chk64("mid_pc_before", dut.pc_q, 64'd8);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk64("mid_pc", dut.pc_q, 64'd0);
        chk64("mid_regs_nonzero", 64'(nonzero_regs()), 64'd0);
        chk64("mid_dmem16", 64'(dut.dmem_q[16]), 64'h23);
        chk64("mid_dmem252", 64'(dut.dmem_q[252]), 64'hFE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
